device_serial_tx: RTL and testbench



---
 rtl/device_serial_tx.sv | 170 +++++++++++++++++
 tb/tb_device_serial_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/device_serial_tx.sv
// device_serial_tx
//   Device-side end of the memory-mapped device handshake. A one-cycle
//   start pulse latches the 32-bit data word. The word is then sent as
//   BYTES_PER_WORD UART frames, LSB byte first, each frame being
//   start(0) + 8 data bits LSB first + stop(1). When the last stop bit
//   ends, finish pulses for one cycle.
//
// Ports
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   start  : transfer request, only accepted in IDLE
//   data   : word to send, sampled in the accepting cycle only
//   tx     : serial line, idles high (registered)
//   busy   : high while a word is in flight (registered)
//   finish : one-cycle pulse after the last stop bit (registered)
module device_serial_tx #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned BYTES_PER_WORD = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data,
    output logic        tx,
    output logic        busy,
    output logic        finish
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [31:0]       word_q, word_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              finish_q, finish_d;

    logic       baud_tick;
    logic [7:0] cur_byte;

    assign baud_tick = (baud_q == BAUD_LAST);
    assign cur_byte  = word_q[{byte_idx_q, 3'b000} +: 8];

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        word_d     = word_q;

        // Outputs are registered copies of what the current state drives,
        // so the line changes one edge after the state does.
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        finish_d = 1'b0;
        case (state_q)
            START_BIT: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA_BITS: begin
                tx_d   = shift_q[0];
                busy_d = 1'b1;
            end
            STOP_BIT: begin
                busy_d = 1'b1;
            end
            DONE: begin
                finish_d = 1'b1;
            end
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d     = data;
                    byte_idx_d = '0;
                    baud_d     = '0;
                    state_d    = START_BIT;
                end
            end
            START_BIT: begin
                if (baud_tick) begin
                    baud_d    = '0;
                    shift_d   = cur_byte;
                    bit_idx_d = '0;
                    state_d   = DATA_BITS;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA_BITS: begin
                if (baud_tick) begin
                    baud_d    = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP_BIT: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = DONE;
                    end else begin
                        // Next frame starts immediately, no idle gap.
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = START_BIT;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            finish_q   <= finish_d;
        end
    end

    assign tx     = tx_q;
    assign busy   = busy_q;
    assign finish = finish_q;

endmodule

// File: tb/tb_device_serial_tx.sv
// Bench for device_serial_tx: two instances (4-byte and 1-byte words,
// 4 clocks per bit) share stimulus; each is compared every cycle against
// a timeline model that derives tx/busy/finish from the number of edges
// since the word was accepted.
module tb_device_serial_tx;

    localparam int C = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data  = '0;
    logic        tx4, busy4, fin4;
    logic        tx1, busy1, fin1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int kb     = 1 << 30;
    bit chk_en = 1'b0;

    device_serial_tx #(.CLKS_PER_BIT(C), .BYTES_PER_WORD(4)) dut4 (
        .clock(clock), .reset(reset), .start(start), .data(data),
        .tx(tx4), .busy(busy4), .finish(fin4)
    );

    device_serial_tx #(.CLKS_PER_BIT(C), .BYTES_PER_WORD(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .data(data),
        .tx(tx1), .busy(busy1), .finish(fin1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected {tx, busy, finish} n edges after the accepting edge.
    function automatic logic [2:0] exp_out(input logic [31:0] w, input int n, input int b);
        int slot, frame, pos;
        if (n <= 0) return 3'b100;
        if (n <= 10 * b * C) begin
            slot  = (n - 1) / C;
            frame = slot / 10;
            pos   = slot % 10;
            if (pos == 0) return 3'b010;
            if (pos == 9) return 3'b110;
            return {w[frame * 8 + pos - 1], 2'b10};
        end
        return 3'b101;
    endfunction

    bit          a4 = 0, a1 = 0;
    int          n4 = 0, n1 = 0;
    logic [31:0] w4, w1;
    logic [2:0]  e4, e1;

    always @(posedge clock) begin
        if (reset) begin
            a4 = 0; e4 = 3'b100;
            a1 = 0; e1 = 3'b100;
        end else begin
            if (a4) begin
                n4++;
                e4 = exp_out(w4, n4, 4);
                if (n4 == 10 * 4 * C + 1) a4 = 0;
            end else begin
                e4 = 3'b100;
                if (start) begin a4 = 1; n4 = 0; w4 = data; end
            end
            if (a1) begin
                n1++;
                e1 = exp_out(w1, n1, 1);
                if (n1 == 10 * 1 * C + 1) a1 = 0;
            end else begin
                e1 = 3'b100;
                if (start) begin a1 = 1; n1 = 0; w1 = data; end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("tx4",     32'(tx4),   32'(e4[2]));
            chk("busy4",   32'(busy4), 32'(e4[1]));
            chk("finish4", 32'(fin4),  32'(e4[0]));
            chk("tx1",     32'(tx1),   32'(e1[2]));
            chk("busy1",   32'(busy1), 32'(e1[1]));
            chk("finish1", 32'(fin1),  32'(e1[0]));
        end
    end

    // History of outputs, indexed by edges since the sequence's first edge.
    logic h_tx4 [0:511];
    logic h_bsy4[0:511];
    logic h_fin4[0:511];
    logic h_tx1 [0:511];
    logic h_fin1[0:511];

    always begin
        @(posedge clock);
        #1;
        if (cyc >= kb && cyc - kb < 512) begin
            h_tx4 [cyc - kb] = tx4;
            h_bsy4[cyc - kb] = busy4;
            h_fin4[cyc - kb] = fin4;
            h_tx1 [cyc - kb] = tx1;
            h_fin1[cyc - kb] = fin1;
        end
    end

    task automatic step(input logic s, input logic [31:0] d, input logic r);
        @(negedge clock);
        start = s;
        data  = d;
        reset = r;
    endtask

    task automatic run_idle(input int n);
        repeat (n) step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic begin_seq(input logic s, input logic [31:0] d);
        @(negedge clock);
        for (int i = 0; i < 512; i++) begin
            h_tx4[i] = 1'b0; h_bsy4[i] = 1'b0; h_fin4[i] = 1'b0;
            h_tx1[i] = 1'b0; h_fin1[i] = 1'b0;
        end
        kb    = cyc + 1;
        start = s;
        data  = d;
        reset = 1'b0;
    endtask

    function automatic int count_fin4(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (h_fin4[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic single_word(input logic [31:0] w);
        int fin_at, bcnt;
        logic [7:0] b;
        begin_seq(1'b1, w);
        run_idle(170);
        fin_at = -1;
        bcnt   = 0;
        for (int i = 0; i <= 170; i++) begin
            if (h_fin4[i] === 1'b1 && fin_at < 0) fin_at = i;
            if (h_bsy4[i] === 1'b1) bcnt++;
        end
        chk("word_finish_edge", 32'(fin_at), 32'd161);
        chk("word_finish_count", 32'(count_fin4(0, 170)), 32'd1);
        chk("word_busy_cycles", 32'(bcnt), 32'd160);
        for (int f = 0; f < 4; f++) begin
            for (int p = 1; p <= 8; p++) b[p - 1] = h_tx4[f * 40 + 4 * p + 2];
            chk("frame_start_bit", 32'(h_tx4[f * 40 + 2]), 32'd0);
            chk("frame_byte", 32'(b), 32'(w[f * 8 +: 8]));
            chk("frame_stop_bit", 32'(h_tx4[f * 40 + 38]), 32'd1);
        end
    endtask

    initial begin
        int fin_at;
        logic [9:0] seq;
        int ones;
        int mode;

        // Reset, then 20 idle cycles.
        repeat (3) @(negedge clock);
        chk_en = 1'b1;
        chk("rst_tx",     32'(tx4),   32'd1);
        chk("rst_busy",   32'(busy4), 32'd0);
        chk("rst_finish", 32'(fin4),  32'd0);
        run_idle(20);
        chk("idle_tx",     32'(tx4),   32'd1);
        chk("idle_busy",   32'(busy4), 32'd0);
        chk("idle_finish", 32'(fin4),  32'd0);

        // Single word, byte order and timing.
        single_word(32'h44332211);

        // 0xA5 on the one-byte instance: exact bit sequence and finish edge.
        begin_seq(1'b1, 32'h000000A5);
        run_idle(170);
        for (int s = 0; s < 10; s++) seq[s] = h_tx1[4 * s + 2];
        chk("a5_sequence", 32'(seq), 32'(10'b1101001010));
        fin_at = -1;
        for (int i = 0; i <= 60; i++) if (h_fin1[i] === 1'b1 && fin_at < 0) fin_at = i;
        chk("a5_finish_edge", 32'(fin_at), 32'd41);

        // Start while busy is ignored.
        begin_seq(1'b1, 32'h00000000);
        run_idle(49);
        step(1'b1, 32'hFFFFFFFF, 1'b0);
        run_idle(250);
        ones = 0;
        for (int i = 1; i <= 160; i++) if (h_tx4[i] === 1'b1) ones++;
        chk("busy_start_tx_ones", 32'(ones), 32'd16);
        chk("busy_start_finishes", 32'(count_fin4(0, 300)), 32'd1);

        // Reset during byte 1 data bits.
        begin_seq(1'b1, $urandom);
        run_idle(59);
        step(1'b0, 32'h0, 1'b1);
        run_idle(100);
        chk("midrst_tx", 32'(h_tx4[60]), 32'd1);
        chk("midrst_busy", 32'(h_bsy4[60]), 32'd0);
        chk("midrst_finishes", 32'(count_fin4(0, 160)), 32'd0);
        single_word($urandom);

        // Start held high: two words with a two-cycle high gap.
        begin_seq(1'b1, $urandom);
        for (int i = 1; i < 200; i++) step(1'b1, $urandom, 1'b0);
        run_idle(200);
        chk("b2b_finishes", 32'(count_fin4(0, 399)), 32'd2);
        chk("b2b_second_finish", 32'(h_fin4[323]), 32'd1);
        chk("b2b_last_stop", 32'(h_tx4[160]), 32'd1);
        chk("b2b_gap_done", 32'(h_tx4[161]), 32'd1);
        chk("b2b_gap_idle", 32'(h_tx4[162]), 32'd1);
        chk("b2b_next_start", 32'(h_tx4[163]), 32'd0);

        // Randomised traffic with occasional resets.
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) mode = $urandom_range(0, 1);
            step(mode == 1 ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 99) < 3),
                 $urandom, $urandom_range(0, 999) < 2);
        end
        run_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
